// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encoding and
// operand mode constants.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD_B = 3'd1,
    ST_LD_A = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic MODE_IMM = 1'b0;
  localparam logic MODE_REG = 1'b1;

endpackage

// File: rtl/onehot_sel_decode.sv
// Register index to one-hot enable decoder; an out-of-range index or a low
// enable yields an all-zero vector.
module onehot_sel_decode #(
  parameter int SEL_W    = 6,
  parameter int NUM_REGS = 5
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // Compare the index against every register position.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control FSM sequencing one ALU operation (dst OP imm or dst OP src) over the
// shared data bus; every output is a flop loaded from the next-state decode.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 5,
  parameter int SEL_W      = 6,
  parameter int IMM_W      = 6,
  parameter int IMM_SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [SEL_W-1:0]    dst_sel,
  input  logic [SEL_W-1:0]    src_sel,
  input  logic [IMM_W-1:0]    imm,
  input  logic                abort,
  input  logic                alu_ready,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic                imm_bus_en,
  output logic [DATA_W-1:0]   imm_data,
  output logic                alu_a_ld,
  output logic                alu_b_ld,
  output logic                alu_go,
  output logic                alu_out_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] v);
    if (IMM_SIGNED != 0) begin
      return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    end else begin
      return {{(DATA_W-IMM_W){1'b0}}, v};
    end
  endfunction

  state_t             state_r, next_state_s;
  logic               mode_r, mode_s;
  logic [SEL_W-1:0]   dst_r, dst_s, src_r, src_s;
  logic [IMM_W-1:0]   imm_r, imm_s;
  logic               legal_s;

  logic               in_flag_s, out_flag_s;
  logic [SEL_W-1:0]   out_idx_s;
  logic [NUM_REGS-1:0] in_onehot_s, out_onehot_s;
  logic               imm_bus_en_s, alu_a_ld_s, alu_b_ld_s, alu_go_s, alu_out_en_s;
  logic               done_s, err_s;
  logic [DATA_W-1:0]  imm_data_s;

  // Transition logic and operand capture; abort overrides everything but reset.
  always_comb begin
    next_state_s = state_r;
    mode_s       = mode_r;
    dst_s        = dst_r;
    src_s        = src_r;
    imm_s        = imm_r;
    legal_s      = (32'(dst_sel) < NUM_REGS_U) &&
                   ((mode != MODE_REG) || (32'(src_sel) < NUM_REGS_U));
    if (abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_s       = mode;
            dst_s        = dst_sel;
            src_s        = src_sel;
            imm_s        = imm;
            next_state_s = legal_s ? ST_LD_B : ST_ERR;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_LD_B: next_state_s = ST_LD_A;
        ST_LD_A: next_state_s = ST_EXEC;
        ST_EXEC: begin
          if (alu_ready) begin
            next_state_s = ST_WB;
          end else begin
            next_state_s = ST_EXEC;
          end
        end
        ST_WB:   next_state_s = ST_DONE;
        ST_DONE: next_state_s = ST_IDLE;
        ST_ERR:  next_state_s = ST_IDLE;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode for the state being entered, so the flops present it in that state.
  always_comb begin
    in_flag_s    = 1'b0;
    out_flag_s   = 1'b0;
    out_idx_s    = dst_s;
    imm_bus_en_s = 1'b0;
    imm_data_s   = '0;
    alu_a_ld_s   = 1'b0;
    alu_b_ld_s   = 1'b0;
    alu_go_s     = 1'b0;
    alu_out_en_s = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (next_state_s)
      ST_LD_B: begin
        alu_b_ld_s = 1'b1;
        if (mode_s == MODE_IMM) begin
          imm_bus_en_s = 1'b1;
          imm_data_s   = ext_imm(imm_s);
        end else begin
          out_flag_s = 1'b1;
          out_idx_s  = src_s;
        end
      end
      ST_LD_A: begin
        out_flag_s = 1'b1;
        alu_a_ld_s = 1'b1;
      end
      ST_EXEC: alu_go_s = 1'b1;
      ST_WB: begin
        alu_out_en_s = 1'b1;
        in_flag_s    = 1'b1;
      end
      ST_DONE: done_s = 1'b1;
      ST_ERR:  err_s  = 1'b1;
      default: begin
        in_flag_s  = 1'b0;
        out_flag_s = 1'b0;
      end
    endcase
  end

  onehot_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_in_dec (
    .idx    (dst_s),
    .en     (in_flag_s),
    .onehot (in_onehot_s)
  );

  onehot_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_out_dec (
    .idx    (out_idx_s),
    .en     (out_flag_s),
    .onehot (out_onehot_s)
  );

  // State, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_IMM;
      dst_r      <= '0;
      src_r      <= '0;
      imm_r      <= '0;
      reg_in_en  <= '0;
      reg_out_en <= '0;
      imm_bus_en <= 1'b0;
      imm_data   <= '0;
      alu_a_ld   <= 1'b0;
      alu_b_ld   <= 1'b0;
      alu_go     <= 1'b0;
      alu_out_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      mode_r     <= mode_s;
      dst_r      <= dst_s;
      src_r      <= src_s;
      imm_r      <= imm_s;
      reg_in_en  <= in_onehot_s;
      reg_out_en <= out_onehot_s;
      imm_bus_en <= imm_bus_en_s;
      imm_data   <= imm_data_s;
      alu_a_ld   <= alu_a_ld_s;
      alu_b_ld   <= alu_b_ld_s;
      alu_go     <= alu_go_s;
      alu_out_en <= alu_out_en_s;
      busy       <= (next_state_s != ST_IDLE);
      done       <= done_s;
      err        <= err_s;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: per-cycle expected output vectors are
// queued when an operation is issued and popped as the DUT produces each cycle.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, mode, abort, alu_ready;
  logic [5:0] dst_sel, src_sel, imm;

  logic [4:0]  reg_in_en, reg_out_en, sx_reg_in_en, sx_reg_out_en;
  logic        imm_bus_en, alu_a_ld, alu_b_ld, alu_go, alu_out_en, busy, done, err;
  logic        sx_imm_bus_en, sx_alu_a_ld, sx_alu_b_ld, sx_alu_go, sx_alu_out_en;
  logic        sx_busy, sx_done, sx_err;
  logic [15:0] imm_data, sx_imm_data;

  int n_vec = 0;
  int n_bad = 0;

  logic [33:0] exp_q[$];
  logic [15:0] exp_sx_q[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(.IMM_SIGNED(0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dst_sel(dst_sel),
    .src_sel(src_sel), .imm(imm), .abort(abort), .alu_ready(alu_ready),
    .reg_in_en(reg_in_en), .reg_out_en(reg_out_en), .imm_bus_en(imm_bus_en),
    .imm_data(imm_data), .alu_a_ld(alu_a_ld), .alu_b_ld(alu_b_ld),
    .alu_go(alu_go), .alu_out_en(alu_out_en), .busy(busy), .done(done), .err(err)
  );

  alu_op_sequencer #(.IMM_SIGNED(1)) dut_sx (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dst_sel(dst_sel),
    .src_sel(src_sel), .imm(imm), .abort(abort), .alu_ready(alu_ready),
    .reg_in_en(sx_reg_in_en), .reg_out_en(sx_reg_out_en), .imm_bus_en(sx_imm_bus_en),
    .imm_data(sx_imm_data), .alu_a_ld(sx_alu_a_ld), .alu_b_ld(sx_alu_b_ld),
    .alu_go(sx_alu_go), .alu_out_en(sx_alu_out_en), .busy(sx_busy), .done(sx_done),
    .err(sx_err)
  );

  task automatic check_eq(input string tag, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic [4:0] in_en, input logic [4:0] out_en,
                                     input logic ibe, input logic [15:0] idata,
                                     input logic a, input logic b, input logic go,
                                     input logic aoe, input logic bsy, input logic dn,
                                     input logic er);
    return {in_en, out_en, ibe, idata, a, b, go, aoe, bsy, dn, er};
  endfunction

  function automatic logic [33:0] observed();
    return {reg_in_en, reg_out_en, imm_bus_en, imm_data, alu_a_ld, alu_b_ld,
            alu_go, alu_out_en, busy, done, err};
  endfunction

  task automatic compare_cycle(input string tag);
    logic [33:0] e;
    logic [15:0] e_sx;
    logic        excl;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_underflow"}, 34'd1, 34'd0);
    end else begin
      e    = exp_q.pop_front();
      e_sx = exp_sx_q.pop_front();
      check_eq(tag, observed(), e);
      check_eq({tag, "_sx_imm"}, {18'd0, sx_imm_data}, {18'd0, e_sx});
    end
    excl = ($countones({imm_bus_en, reg_out_en, alu_out_en}) <= 1) &&
           ($countones({sx_imm_bus_en, sx_reg_out_en, sx_alu_out_en}) <= 1);
    check_eq({tag, "_bus_excl"}, {33'd0, excl}, 34'd1);
  endtask

  // ev: 0 none, 1 abort, 2 reset, 3 extra start pulse; applied in cycle ev_c
  task automatic run_op(input logic m, input logic [5:0] d, input logic [5:0] s,
                        input logic [5:0] im, input int stall, input int ev,
                        input int ev_c, input string tag);
    logic        legal;
    logic [4:0]  doh, soh;
    logic [15:0] ext0, ext1;
    int          ncyc;
    legal = (d < 6'd5) && (!m || (s < 6'd5));
    doh   = 5'd0;
    soh   = 5'd0;
    if (d < 6'd5) doh[d[2:0]] = 1'b1;
    if (s < 6'd5) soh[s[2:0]] = 1'b1;
    ext0 = {10'd0, im};
    ext1 = {{10{im[5]}}, im};
    ncyc = legal ? 8 + stall : 3;
    for (int c = 1; c <= ncyc; c++) begin
      logic [33:0] e;
      logic [15:0] e_sx;
      e    = 34'd0;
      e_sx = 16'd0;
      if ((ev == 1 || ev == 2) && c > ev_c) begin
        e = 34'd0;
      end else if (!legal) begin
        if (c == 1) e = mk(5'd0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end else if (c == 1) begin
        if (!m) begin
          e    = mk(5'd0, 5'd0, 1'b1, ext0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
          e_sx = ext1;
        end else begin
          e = mk(5'd0, soh, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
      end else if (c == 2) begin
        e = mk(5'd0, doh, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else if (c <= 3 + stall) begin
        e = mk(5'd0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end else if (c == 4 + stall) begin
        e = mk(doh, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end else if (c == 5 + stall) begin
        e = mk(5'd0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      exp_q.push_back(e);
      exp_sx_q.push_back(e_sx);
    end

    @(negedge clk);
    mode      = m;
    dst_sel   = d;
    src_sel   = s;
    imm       = im;
    start     = 1'b1;
    alu_ready = (stall == 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      mode    = ~m;
      dst_sel = d ^ 6'd3;
      src_sel = s ^ 6'd6;
      imm     = ~im;
      compare_cycle($sformatf("%s_c%0d", tag, c));
      start     = (ev == 3) && (c == ev_c);
      abort     = (ev == 1) && (c == ev_c);
      rst       = (ev == 2) && (c == ev_c);
      alu_ready = (stall == 0) || (c >= 3 + stall);
    end
    rst   = 1'b0;
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    abort     = 1'b0;
    alu_ready = 1'b0;
    dst_sel   = 6'd0;
    src_sel   = 6'd0;
    imm       = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(34'd0);
    exp_sx_q.push_back(16'd0);
    compare_cycle("reset");
    rst = 1'b0;

    run_op(1'b0, 6'd2, 6'd0,  6'h2A, 0, 0, 0, "imm_dst2");
    run_op(1'b1, 6'd4, 6'd1,  6'h00, 3, 0, 0, "reg_p0_r1");
    run_op(1'b0, 6'd1, 6'd0,  6'h3F, 0, 0, 0, "imm_neg");
    run_op(1'b0, 6'd7, 6'd0,  6'h05, 0, 0, 0, "bad_dst");
    run_op(1'b1, 6'd0, 6'd5,  6'h00, 0, 0, 0, "bad_src");
    run_op(1'b0, 6'd4, 6'd63, 6'h11, 1, 0, 0, "imm_src_ignored");
    run_op(1'b1, 6'd3, 6'd3,  6'h00, 1, 0, 0, "src_eq_dst");
    run_op(1'b0, 6'd0, 6'd0,  6'h05, 0, 1, 2, "abort_lda");
    run_op(1'b1, 6'd2, 6'd0,  6'h00, 0, 3, 2, "dbl_start");
    run_op(1'b1, 6'd1, 6'd2,  6'h00, 5, 2, 4, "rst_exec");

    // abort together with start in IDLE: the start is dropped
    @(negedge clk);
    dst_sel = 6'd1;
    mode    = 1'b0;
    start   = 1'b1;
    abort   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(34'd0);
      exp_sx_q.push_back(16'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      compare_cycle($sformatf("abort_start_c%0d", c));
    end

    check_eq("queue_empty", 34'(exp_q.size()), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised control FSM that sequences one ALU operation on the microcontroller datapath.
- Supports two modes:
  - immediate: dst <= dst OP imm
  - register-register: dst <= dst OP src
- Decodes register selects into one-hot in/out enables for a configurable register file (R0..Rn, port registers).
- Sits between the instruction decoder (start, selects, immediate) and the shared data bus/ALU.
- Start is a single pulse and the FSM self-advances. It waits on an ALU ready handshake, and flags illegal selects.

Parameters:
- DATA_W, 16, data bus and ALU operand width
- NUM_REGS, 5, number of addressable registers (index 0..NUM_REGS-1; default maps R0,R1,R2,R3,P0)
- SEL_W, 6, width of dst_sel/src_sel fields
- IMM_W, 6, width of immediate field
- IMM_SIGNED, 0, 1 = sign-extend imm to DATA_W, 0 = zero-extend

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = immediate, 1 = register-register
- dst_sel  in  SEL_W  destination/first operand register index
- src_sel  in  SEL_W  source register index (mode=1 only)
- imm  in  IMM_W  immediate operand (mode=0 only)
- abort  in  1  synchronous cancel (fetch restart), returns to IDLE
- alu_ready  in  1  ALU result valid handshake
- reg_in_en  out  NUM_REGS  one-hot register load-from-bus enables
- reg_out_en  out  NUM_REGS  one-hot register drive-bus enables
- imm_bus_en  out  1  top level drives imm_data onto bus
- imm_data  out  DATA_W  extended immediate
- alu_a_ld  out  1  ALU operand A register load
- alu_b_ld  out  1  ALU operand B register load
- alu_go  out  1  ALU execute/result-latch strobe
- alu_out_en  out  1  ALU result drives bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-select pulse

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - All outputs 0, including imm_data=0. No tri-state values inside this block.
- Outputs are Moore-decoded from the state register and the latched operand registers only. They never depend combinationally on start/mode/sel inputs.
- Operand latch:
  - In IDLE with start=1, mode/dst_sel/src_sel/imm are captured.
  - Later input changes have no effect until the next accepted start.
- Legality check at acceptance:
  - Illegal if dst_sel >= NUM_REGS, or mode=1 and src_sel >= NUM_REGS.
  - Illegal select -> ERR state.
- States and transitions:
  - IDLE: all outputs 0. start -> legal ? LD_B : ERR.
  - LD_B: alu_b_ld=1.
    - mode=0: imm_bus_en=1, imm_data=ext(imm).
    - mode=1: reg_out_en[src]=1.
    - -> LD_A.
  - LD_A: reg_out_en[dst]=1, alu_a_ld=1. -> EXEC.
  - EXEC: alu_go=1. alu_ready=1 -> WB, else stay (unbounded wait).
  - WB: alu_out_en=1, reg_in_en[dst]=1. -> DONE.
  - DONE: done=1. -> IDLE.
  - ERR: err=1, no enables. -> IDLE.
- Latency: start accepted at edge N, with alu_ready high on entry to EXEC:
  - LD_B in cycle N+1, LD_A N+2, EXEC N+3, WB N+4, done high in cycle N+5.
  - Each extra cycle alu_ready is low adds one cycle.
- Bus exclusivity: at most one of {imm_bus_en, any reg_out_en, alu_out_en} is high in any cycle.
- mode=1 with src==dst is legal. Register drives bus in both LD_B and LD_A.
- start while busy: ignored, not queued.
- start in DONE/ERR cycle: ignored. A new start is accepted only in IDLE.
- abort:
  - From any state, next state=IDLE.
  - No done/err generated; outputs 0 the following cycle.
  - Priority: rst > abort > normal transitions.
  - abort and start together in IDLE: abort wins, start dropped.
- Unused/unreachable state encodings -> IDLE.

Decomposition:
- Shared package alu_seq_pkg:
  - state enum/localparams (IDLE, LD_B, LD_A, EXEC, WB, DONE, ERR)
  - mode constants MODE_IMM=0, MODE_REG=1
- Sub-module onehot_sel_decode (parameters SEL_W, NUM_REGS):
  - index + enable -> one-hot vector.
  - All-zero output for out-of-range index.
  - Instantiated for reg_in_en and reg_out_en.

Test Plan:
- Reset mid-EXEC (rst pulse while waiting on alu_ready) -> next cycle state IDLE, all outputs 0, no done.
- mode=0, dst=2, imm=6'h2A, IMM_SIGNED=0, alu_ready tied 1 -> LD_B: imm_bus_en=1, imm_data=16'h002A. reg_out_en=5'b00100 in LD_A. reg_in_en=5'b00100 in WB. done exactly 5 cycles after start.
- mode=1, dst=4 (P0), src=1, alu_ready low for 3 EXEC cycles -> reg_out_en=5'b00010 then 5'b10000. EXEC lasts 4 cycles. done at start+8.
- IMM_SIGNED=1, imm=6'h3F -> imm_data=16'hFFFF in LD_B.
- dst_sel=6'd7 (NUM_REGS=5) with start -> err pulse one cycle later, no enable ever high, back to IDLE.
- abort during LD_A -> IDLE next cycle, no done. Second start pulse during busy of a fresh op ignored (single done only). Bus-exclusivity assertion holds throughout.
